// File: rtl/mips_defs_pkg.sv
// ============================================================================
// Module      : mips_defs
// Description : Shared constants and types for the MIPS pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam int          c_bus_width = 32;
    localparam logic [31:0] c_nop       = 32'h0000_0000;
    localparam logic [31:0] c_halt_word = 32'hFFFF_FFFF;
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, clear-to-NOP and valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_defs::*;
#(
    parameter int BUS_WIDTH = c_bus_width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 clear,
    input  logic [BUS_WIDTH-1:0] instr_in,
    input  logic [BUS_WIDTH-1:0] pc_plus4_in,
    output logic [BUS_WIDTH-1:0] instr,
    output logic [BUS_WIDTH-1:0] pc_plus4,
    output logic                 valid
);

    localparam logic [BUS_WIDTH-1:0] c_nop_word = BUS_WIDTH'(c_nop);

    logic [BUS_WIDTH-1:0] r_instr;
    logic [BUS_WIDTH-1:0] r_pc_plus4;
    logic                 r_valid;

    // hold outranks clear so a stalled bubble stays a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= c_nop_word;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (hold) begin
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (clear) begin
            r_instr    <= c_nop_word;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_instr    <= instr_in;
            r_pc_plus4 <= pc_plus4_in;
            r_valid    <= 1'b1;
        end
    end

    assign instr    = r_instr;
    assign pc_plus4 = r_pc_plus4;
    assign valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction-fetch stage: PC, halt FSM, fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import mips_defs::*;
#(
    parameter int                   BUS_WIDTH   = c_bus_width,
    parameter int                   IMEM_ADDR_W = 10,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = BUS_WIDTH'(c_reset_pc),
    parameter logic [BUS_WIDTH-1:0] HALT_WORD   = BUS_WIDTH'(c_halt_word)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [BUS_WIDTH-1:0]   pc_next_in,
    output logic [BUS_WIDTH-1:0]   pc_plus4,
    output logic [BUS_WIDTH-1:0]   pc,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [BUS_WIDTH-1:0]   imem_data,
    output logic [BUS_WIDTH-1:0]   if_id_instr,
    output logic [BUS_WIDTH-1:0]   if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic                   halted,
    output logic [BUS_WIDTH-1:0]   fetch_count
);

    logic [BUS_WIDTH-1:0] r_pc;
    logic [BUS_WIDTH-1:0] r_fetch_count;
    fetch_state_t         r_state;

    logic [BUS_WIDTH-1:0] w_pc_plus4;
    logic [BUS_WIDTH-1:0] w_pc_load;
    logic                 w_hold;
    logic                 w_clear;

    assign w_pc_plus4 = r_pc + BUS_WIDTH'(4);
    // Misaligned targets are truncated to a word boundary
    assign w_pc_load  = pc_next_in & ~BUS_WIDTH'(3);
    assign w_hold     = !enable || (stall && !flush);
    assign w_clear    = flush || (r_state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_state       <= ST_RUN;
        end else if (enable) begin
            if (flush) begin
                r_pc    <= w_pc_load;
                r_state <= ST_RUN;
            end else if (!stall && r_state == ST_RUN) begin
                r_pc          <= w_pc_load;
                r_fetch_count <= r_fetch_count + BUS_WIDTH'(1);
                if (imem_data == HALT_WORD) begin
                    r_state <= ST_HALTED;
                end
            end
        end
    end

    if_id_reg #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .hold        (w_hold),
        .clear       (w_clear),
        .instr_in    (imem_data),
        .pc_plus4_in (w_pc_plus4),
        .instr       (if_id_instr),
        .pc_plus4    (if_id_pc_plus4),
        .valid       (if_id_valid)
    );

    assign pc_plus4    = w_pc_plus4;
    assign pc          = r_pc;
    assign imem_addr   = r_pc[IMEM_ADDR_W+1:2];
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Vector-table and scoreboard bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, enable, stall, flush;
    logic        seq_mode;
    logic [31:0] nxt_val;
    logic [31:0] pc_next_in, pc_plus4, pc, imem_data;
    logic [9:0]  imem_addr;
    logic [31:0] if_id_instr, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Word 8 (byte 0x20) holds HALT; every other word reads as byte address + 1
    assign imem_data  = (imem_addr == 10'd8) ? 32'hFFFF_FFFF : ({20'd0, imem_addr, 2'b00} + 32'd1);
    assign pc_next_in = seq_mode ? pc_plus4 : nxt_val;

    if_stage #(
        .BUS_WIDTH   (32),
        .IMEM_ADDR_W (10),
        .RESET_PC    (32'h0000_0000),
        .HALT_WORD   (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .stall          (stall),
        .flush          (flush),
        .pc_next_in     (pc_next_in),
        .pc_plus4       (pc_plus4),
        .pc             (pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        en, st, fl, seq;
        logic [31:0] nxt;
        logic [31:0] pc, instr;
        logic        v, h;
        logic [31:0] cnt;
        logic        acc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    localparam int c_nvec = 20;
    vec_t tbl [c_nvec];
    sb_t  sbq [$];

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a[11:2] == 10'd8) return 32'hFFFF_FFFF;
        return {20'd0, a[11:2], 2'b00} + 32'd1;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic st, input logic fl, input logic sq, input logic [31:0] nx);
        enable   = en;
        stall    = st;
        flush    = fl;
        seq_mode = sq;
        nxt_val  = nx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input int row, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_v, input logic e_h, input logic [31:0] e_cnt);
        chk("pc",          row, pc, e_pc);
        chk("pc_plus4",    row, pc_plus4, e_pc + 32'd4);
        chk("imem_addr",   row, {22'd0, imem_addr}, {22'd0, e_pc[11:2]});
        chk("if_id_instr", row, if_id_instr, e_instr);
        chk("if_id_valid", row, {31'd0, if_id_valid}, {31'd0, e_v});
        chk("halted",      row, {31'd0, halted}, {31'd0, e_h});
        chk("fetch_count", row, fetch_count, e_cnt);
    endtask

    initial begin
        logic [31:0] prev_pc;
        sb_t         e;

        //             en    st    fl    seq   nxt            pc             instr          v     h     cnt    acc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h4,         32'h1,         1'b1, 1'b0, 32'd1,  1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h8,         32'h5,         1'b1, 1'b0, 32'd2,  1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h8,         32'h5,         1'b1, 1'b0, 32'd2,  1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h8,         32'h5,         1'b1, 1'b0, 32'd2,  1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'hC,         32'h9,         1'b1, 1'b0, 32'd3,  1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40,        32'h40,        32'h0,         1'b0, 1'b0, 32'd3,  1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h44,        32'h41,        1'b1, 1'b0, 32'd4,  1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20,        32'h20,        32'h0,         1'b0, 1'b0, 32'd4,  1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h20,        32'h0,         1'b0, 1'b0, 32'd4,  1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h24,        32'hFFFF_FFFF, 1'b1, 1'b1, 32'd5,  1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h24,        32'h0,         1'b0, 1'b1, 32'd5,  1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h24,        32'h0,         1'b0, 1'b1, 32'd5,  1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100,       32'h100,       32'h0,         1'b0, 1'b0, 32'd5,  1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h104,       32'h101,       1'b1, 1'b0, 32'd6,  1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h108,       32'h105,       1'b1, 1'b0, 32'd7,  1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h108,       32'h105,       1'b1, 1'b0, 32'd7,  1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h108,       32'h105,       1'b1, 1'b0, 32'd7,  1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h10C,       32'h109,       1'b1, 1'b0, 32'd8,  1'b1};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h10D,       1'b1, 1'b0, 32'd9,  1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         32'hFFD,       1'b1, 1'b0, 32'd10, 1'b1};

        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        tick();
        chk_state(-1, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("if_id_pc_plus4", -1, if_id_pc_plus4, 32'h0);
        reset = 1'b0;

        prev_pc = 32'h0;
        for (int i = 0; i < c_nvec; i++) begin
            drive(tbl[i].en, tbl[i].st, tbl[i].fl, tbl[i].seq, tbl[i].nxt);
            if (tbl[i].acc) sbq.push_back('{imem_fn(prev_pc), prev_pc + 32'd4});
            tick();
            chk_state(i, tbl[i].pc, tbl[i].instr, tbl[i].v, tbl[i].h, tbl[i].cnt);
            if (tbl[i].acc) begin
                if (sbq.size() == 0) begin
                    chk("scoreboard_empty", i, 32'd0, 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_instr", i, if_id_instr, e.instr);
                    chk("sb_pc_plus4", i, if_id_pc_plus4, e.pc4);
                end
            end
            prev_pc = tbl[i].pc;
        end

        // Reset while halted, with enable low and every other control active
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h20);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk_state(100, 32'h24, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd11);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
        tick();
        chk_state(101, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("if_id_pc_plus4", 101, if_id_pc_plus4, 32'h0);

        // Reset mid-stall, then a clean restart
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        chk_state(102, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk_state(103, 32'h4, 32'h1, 1'b1, 1'b0, 32'd1);
        chk("if_id_pc_plus4", 103, if_id_pc_plus4, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
